// File: rtl/d_fd_reg_if.sv
// Fetch/decode handshake bundle.
// Fetch drives the i_* side, decode reads the or_* side.
interface d_fd_reg_if;
  logic        i_en;
  logic        i_Req;
  logic        i_flush;
  logic [31:0] i_pc;
  logic [31:0] i_instr;
  logic        i_bd;
  logic [31:0] or_pc;
  logic [31:0] or_instr;
  logic [4:0]  or_excCode;
  logic        or_bd;
  logic        or_valid;

  modport master (
    output i_en, i_Req, i_flush,
    output i_pc, i_instr, i_bd,
    input  or_pc, or_instr, or_excCode,
    input  or_bd, or_valid
  );

  modport slave (
    input  i_en, i_Req, i_flush,
    input  i_pc, i_instr, i_bd,
    output or_pc, or_instr, or_excCode,
    output or_bd, or_valid
  );
endinterface

// File: rtl/d_fd_reg.sv
// Fetch/decode pipeline register with fetch AdEL detection,
// delay-slot flag and request/flush bubble insertion.
module d_fd_reg #(
  parameter logic [31:0] PC_DEFAULT = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY  = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_END     = 32'h0000_6FFF,
  parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
  input logic         i_clk,
  input logic         i_reset,
  d_fd_reg_if.slave   fd
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
    logic        valid;
  } fd_t;

  localparam fd_t FD_RST = '{
    pc:    PC_DEFAULT,
    instr: 32'h0,
    exc:   5'd0,
    bd:    1'b0,
    valid: 1'b0
  };

  fd_t q;
  fd_t d;

  logic misal;
  logic below;
  logic above;
  logic adel;

  assign misal = |fd.i_pc[1:0];
  assign below = fd.i_pc < IM_BASE;
  assign above = fd.i_pc > IM_END;
  assign adel  = misal | below | above;

  // Request outranks flush, both outrank stall.
  always_comb begin
    d = q;
    priority case (1'b1)
      fd.i_Req: begin
        d.pc    = EXC_ENTRY;
        d.instr = 32'h0;
        d.exc   = 5'd0;
        d.bd    = 1'b0;
        d.valid = 1'b0;
      end
      fd.i_flush: begin
        d.pc    = fd.i_pc;
        d.instr = 32'h0;
        d.exc   = 5'd0;
        d.bd    = 1'b0;
        d.valid = 1'b0;
      end
      fd.i_en: begin
        d.pc    = fd.i_pc;
        d.bd    = fd.i_bd;
        d.valid = 1'b1;
        d.exc   = adel ? EXC_ADEL : 5'd0;
        d.instr = adel ? 32'h0 : fd.i_instr;
      end
      default: d = q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) q <= FD_RST;
    else         q <= d;
  end

  assign fd.or_pc      = q.pc;
  assign fd.or_instr   = q.instr;
  assign fd.or_excCode = q.exc;
  assign fd.or_bd      = q.bd;
  assign fd.or_valid   = q.valid;

endmodule

// File: tb/tb_d_fd_reg.sv
// Directed bench for the fetch/decode register.
// Vectors and expected values are hand-derived.
module tb_d_fd_reg;

  logic i_clk;
  logic i_reset;
  int   n_chk;
  int   n_err;

  d_fd_reg_if fd ();

  d_fd_reg dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .fd      (fd.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(
    input string       tag,
    input logic [31:0] pc,
    input logic [31:0] instr,
    input logic [4:0]  exc,
    input logic        bd,
    input logic        valid
  );
    chk({tag, ".pc"},    fd.or_pc,            pc);
    chk({tag, ".instr"}, fd.or_instr,         instr);
    chk({tag, ".exc"},   {27'h0, fd.or_excCode}, {27'h0, exc});
    chk({tag, ".bd"},    {31'h0, fd.or_bd},   {31'h0, bd});
    chk({tag, ".valid"}, {31'h0, fd.or_valid}, {31'h0, valid});
  endtask

  task automatic cyc(
    input logic        en,
    input logic        req,
    input logic        flush,
    input logic [31:0] pc,
    input logic [31:0] instr,
    input logic        bd
  );
    @(negedge i_clk);
    fd.i_en    = en;
    fd.i_Req   = req;
    fd.i_flush = flush;
    fd.i_pc    = pc;
    fd.i_instr = instr;
    fd.i_bd    = bd;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    i_reset    = 1'b1;
    fd.i_en    = 1'b0;
    fd.i_Req   = 1'b0;
    fd.i_flush = 1'b0;
    fd.i_pc    = 32'h0;
    fd.i_instr = 32'h0;
    fd.i_bd    = 1'b0;

    repeat (2) @(posedge i_clk);
    #1;
    chk_all("rst", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);

    @(negedge i_clk);
    i_reset = 1'b0;
    cyc(1, 0, 0, 32'h3004, 32'h3C01_1234, 0);
    chk_all("load0", 32'h3004, 32'h3C01_1234, 5'd0, 1'b0, 1'b1);

    // Stall for three edges while fetch PC moves on.
    cyc(1, 0, 0, 32'h3008, 32'h2021_0001, 0);
    chk_all("load1", 32'h3008, 32'h2021_0001, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 32'h300C, 32'h2021_0002, 0);
      chk_all("stall", 32'h3008, 32'h2021_0001, 5'd0, 1'b0, 1'b1);
    end
    cyc(1, 0, 0, 32'h300C, 32'h2021_0002, 0);
    chk_all("unstall", 32'h300C, 32'h2021_0002, 5'd0, 1'b0, 1'b1);

    cyc(1, 0, 0, 32'h3002, 32'hDEAD_BEEF, 0);
    chk_all("misal", 32'h3002, 32'h0, 5'd4, 1'b0, 1'b1);
    cyc(1, 0, 0, 32'h7000, 32'hDEAD_BEEF, 1);
    chk_all("hi_oob", 32'h7000, 32'h0, 5'd4, 1'b1, 1'b1);
    cyc(1, 0, 0, 32'h2FFC, 32'hDEAD_BEEF, 0);
    chk_all("lo_oob", 32'h2FFC, 32'h0, 5'd4, 1'b0, 1'b1);
    cyc(1, 0, 0, 32'h6FFC, 32'h1234_5678, 0);
    chk_all("top_ok", 32'h6FFC, 32'h1234_5678, 5'd0, 1'b0, 1'b1);
    cyc(1, 0, 0, 32'h6FFE, 32'h1234_5678, 0);
    chk_all("both", 32'h6FFE, 32'h0, 5'd4, 1'b0, 1'b1);
    cyc(1, 0, 0, 32'h3000, 32'h0000_0001, 0);
    chk_all("base_ok", 32'h3000, 32'h0000_0001, 5'd0, 1'b0, 1'b1);

    // Request must not be delayed by a stall.
    cyc(1, 0, 0, 32'h3014, 32'h1111_2222, 1);
    chk_all("bd_load", 32'h3014, 32'h1111_2222, 5'd0, 1'b1, 1'b1);
    cyc(0, 1, 0, 32'h3018, 32'h3333_4444, 1);
    chk_all("req_stall", 32'h4180, 32'h0, 5'd0, 1'b0, 1'b0);
    cyc(0, 0, 0, 32'h301C, 32'h5555_6666, 1);
    chk_all("hold_bub", 32'h4180, 32'h0, 5'd0, 1'b0, 1'b0);
    cyc(1, 0, 0, 32'h3020, 32'h7777_8888, 1);
    chk_all("bd_load2", 32'h3020, 32'h7777_8888, 5'd0, 1'b1, 1'b1);
    cyc(1, 1, 1, 32'h3024, 32'h9999_AAAA, 1);
    chk_all("req_flush", 32'h4180, 32'h0, 5'd0, 1'b0, 1'b0);

    cyc(1, 0, 0, 32'h3028, 32'hBBBB_CCCC, 1);
    chk_all("bd_load3", 32'h3028, 32'hBBBB_CCCC, 5'd0, 1'b1, 1'b1);
    cyc(0, 0, 1, 32'h3010, 32'hDDDD_EEEE, 1);
    chk_all("flush", 32'h3010, 32'h0, 5'd0, 1'b0, 1'b0);
    cyc(1, 0, 1, 32'h7000, 32'hDDDD_EEEE, 1);
    chk_all("flush_bad", 32'h7000, 32'h0, 5'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a stall.
    cyc(1, 0, 0, 32'h4000, 32'h0F0F_0F0F, 1);
    chk_all("pre_rst", 32'h4000, 32'h0F0F_0F0F, 5'd0, 1'b1, 1'b1);
    cyc(0, 0, 0, 32'h4004, 32'h0, 0);
    #2;
    i_reset = 1'b1;
    #1;
    chk_all("async_rst", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    chk_all("rst_hold", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_reset = 1'b0;
    cyc(1, 0, 0, 32'h3030, 32'h2400_0005, 0);
    chk_all("post_rst", 32'h3030, 32'h2400_0005, 5'd0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
